clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Mode and step controller for the digital-clock counter chain. Sits between the debounced front-panel buttons, the 1 Hz tick source and the seconds/minutes/hours counter chain. Runs the chain from the tick in normal mode, and lets the user set hours, minutes and seconds with the increment button. Each counter's `carryin` is driven from this block's step outputs, and each counter's `carryout` returns here as a carry input.

## Interface
Parameters:
- `TIMEOUT_S`, default 10: number of 1 Hz ticks without a button press before a set mode returns to RUN. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `tick_1hz`  in  1  one-cycle pulse per second
- `btn_mode`  in  1  debounced single-cycle pulse; advances the mode
- `btn_inc`  in  1  debounced single-cycle pulse; steps the selected field
- `sec_carry`  in  1  seconds counter `carryout`
- `min_carry`  in  1  minutes counter `carryout`
- `sec_step`  out  1  registered pulse to the seconds counter `carryin`
- `min_step`  out  1  registered pulse to the minutes counter `carryin`
- `hour_step`  out  1  registered pulse to the hours counter `carryin`
- `sec_clr`  out  1  registered pulse to the seconds counter `rst`
- `mode`  out  2  current mode
- `blink`  out  1  display blank for the field being set

## Operation
- Modes: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
- Mode changes on `btn_mode`: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- RUN:
  - `sec_step` = `tick_1hz`.
  - `min_step` = `sec_carry`.
  - `hour_step` = `min_carry`.
  - `btn_inc` is ignored.
- SET_HOUR: `hour_step` = `btn_inc`; all other steps are 0.
- SET_MIN: `min_step` = `btn_inc`; all other steps are 0.
- SET_SEC: `btn_inc` gives a `sec_clr` pulse (seconds go to 00); no step pulses.
- In every set mode, ticks are not forwarded, so the clock is frozen. Counter carries are ignored, so there is no ripple into the next field while setting.
- Timeout:
  - In a set mode, an idle counter counts `tick_1hz` pulses.
  - Any `btn_mode` or `btn_inc` pulse clears it.
  - When the counter reaches `TIMEOUT_S`, the mode goes to RUN and the counter clears.
  - The counter is held at 0 in RUN.
  - Counter width is `$clog2(TIMEOUT_S+1)`, minimum 1.
- Simultaneous events:
  - `btn_mode` and `btn_inc` in the same cycle: the mode advances and `btn_inc` is dropped.
  - `btn_mode` and a timeout in the same cycle: the button wins (normal advance; the counter clears).
  - `tick_1hz` and a carry in the same cycle in RUN: both are forwarded independently.
- Reset: in any state, `rst` forces mode RUN and clears all outputs, the idle counter and `blink` to 0 on the next edge.

## Timing
- All outputs are registered. Each step/clear pulse is exactly 1 cycle, appearing 1 cycle after its cause.
- Ripple latency in RUN: `tick_1hz` at cycle n → `sec_step` at n+1. If the counter wraps, `sec_carry` arrives at n+2 and `min_step` at n+3. `hour_step` follows `min_carry` with the same 1-cycle latency.
- A mode change is visible on `mode` 1 cycle after `btn_mode`. The step routing for the new mode applies from that cycle onward.
- A carry arriving in the cycle the mode leaves RUN is routed by the old (registered) mode. This is accepted: at most one field step.
- Reset values: `mode`=0, `sec_step`=`min_step`=`hour_step`=`sec_clr`=0, `blink`=0.

## Configuration
- `CLOCK_SET_BLINK_EN` defined:
  - In a set mode, `blink` toggles on each `tick_1hz`.
  - `blink` is forced to 0 on entering RUN and on any `btn_inc`, so the value just set stays visible.
- Not defined: `blink` is tied to 0 and the toggle flop is not built.

## Structure
- Shared package `clock_pkg` holds:
  - the mode typedef `clk_mode_t` (2-bit enum, values as above);
  - the constant `CLK_MODE_W` = 2.
- Sub-module `set_timeout`:
  - contains the idle counter;
  - inputs: `clk`, `rst`, `active`, `tick`, `kick`;
  - output: a one-cycle `expire` pulse;
  - parameter `TIMEOUT_S`.
- The top level holds the mode FSM, the step routing and the blink flop.

## Test plan
- Reset mid-SET_MIN with `btn_inc` pending → next cycle `mode`=0, all outputs 0, no `min_step`.
- RUN, `tick_1hz` at cycle 10, `sec_carry` returned at 12 → `sec_step`=1 at 11, `min_step`=1 at 13, no other pulses.
- Four `btn_mode` pulses → `mode` sequence 1, 2, 3, 0. In SET_HOUR, 3 `btn_inc` pulses → exactly 3 `hour_step` pulses and 0 `sec_step` while ticks run.
- `btn_mode` and `btn_inc` in the same cycle in SET_HOUR → `mode`=2, no `hour_step`. In SET_SEC, `btn_inc` → one `sec_clr` pulse.
- `TIMEOUT_S`=3, enter SET_HOUR, no buttons → `mode`=0 one cycle after the 3rd tick. A `btn_inc` after the 2nd tick delays the return to the 5th tick.
- With `CLOCK_SET_BLINK_EN`, 4 ticks in SET_MIN → `blink` 1, 0, 1, 0; `btn_inc` → `blink`=0. Without the macro, `blink` stays 0 throughout.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types for the digital-clock set controller.
//   clk_mode_t : RUN / SET_HOUR / SET_MIN / SET_SEC mode encoding
//   CLK_MODE_W : width of the mode field
//   next_mode  : mode advance order on btn_mode (wraps SET_SEC -> RUN)
package clock_pkg;
  localparam int CLK_MODE_W = 2;

  typedef enum logic [CLK_MODE_W-1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } clk_mode_t;

  function automatic clk_mode_t next_mode(input clk_mode_t m);
    case (m)
      MODE_RUN:      return MODE_SET_HOUR;
      MODE_SET_HOUR: return MODE_SET_MIN;
      MODE_SET_MIN:  return MODE_SET_SEC;
      default:       return MODE_RUN;
    endcase
  endfunction
endpackage

// File: rtl/set_timeout.sv
// set_timeout: idle counter that ends a set mode after TIMEOUT_S quiet ticks.
//   clk, rst : clock, synchronous active-high reset
//   active   : 1 while in a set mode; counter held at 0 otherwise
//   tick     : 1 Hz pulse, counted while active
//   kick     : any button pulse; clears the counter
//   expire   : one-cycle pulse in the cycle of the TIMEOUT_S-th quiet tick
// TIMEOUT_S = 0 disables expiry entirely.
module set_timeout #(
  parameter int TIMEOUT_S = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic tick,
  input  logic kick,
  output logic expire
);
  localparam int CW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  // Expiry fires on the tick that would take the count to TIMEOUT_S, so the
  // registered mode returns to RUN one cycle after that tick.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_S - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!active || kick) begin
      cnt_d = '0;
    end else if (tick && (TIMEOUT_S != 0)) begin
      if (cnt_q == LAST) begin
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode FSM and step router for the sec/min/hour counter chain.
//   clk, rst          : clock, synchronous active-high reset
//   tick_1hz          : 1 Hz pulse
//   btn_mode, btn_inc : debounced single-cycle button pulses
//   sec_carry         : seconds counter carryout
//   min_carry         : minutes counter carryout
//   sec_step, min_step, hour_step : registered carryin pulses to the counters
//   sec_clr           : registered clear pulse to the seconds counter
//   mode              : current mode (clk_mode_t)
//   blink             : blank the field being set
// Optional feature macro CLOCK_SET_BLINK_EN builds the blink toggle flop;
// without it blink is tied to 0.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  input  logic                  sec_carry,
  input  logic                  min_carry,
  output logic                  sec_step,
  output logic                  min_step,
  output logic                  hour_step,
  output logic                  sec_clr,
  output logic [CLK_MODE_W-1:0] mode,
  output logic                  blink
);
  clk_mode_t mode_q, mode_d;
  logic sec_step_q, sec_step_d;
  logic min_step_q, min_step_d;
  logic hour_step_q, hour_step_d;
  logic sec_clr_q, sec_clr_d;
  logic inc, expire;

  set_timeout #(.TIMEOUT_S(TIMEOUT_S)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .active (mode_q != MODE_RUN),
    .tick   (tick_1hz),
    .kick   (btn_mode | btn_inc),
    .expire (expire)
  );

  always_comb begin
    // A mode press in the same cycle swallows the increment.
    inc         = btn_inc & ~btn_mode;
    mode_d      = mode_q;
    if (btn_mode)    mode_d = next_mode(mode_q);
    else if (expire) mode_d = MODE_RUN;

    // Routing uses the registered mode, so a carry landing in the cycle we
    // leave RUN still ripples once.
    sec_step_d  = 1'b0;
    min_step_d  = 1'b0;
    hour_step_d = 1'b0;
    sec_clr_d   = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        sec_step_d  = tick_1hz;
        min_step_d  = sec_carry;
        hour_step_d = min_carry;
      end
      MODE_SET_HOUR: hour_step_d = inc;
      MODE_SET_MIN:  min_step_d  = inc;
      MODE_SET_SEC:  sec_clr_d   = inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_RUN;
      sec_step_q  <= 1'b0;
      min_step_q  <= 1'b0;
      hour_step_q <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      sec_step_q  <= sec_step_d;
      min_step_q  <= min_step_d;
      hour_step_q <= hour_step_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

`ifdef CLOCK_SET_BLINK_EN
  logic blink_q, blink_d;

  // Blank on alternate seconds while setting; show the field solid right
  // after an increment and whenever running.
  always_comb begin
    blink_d = blink_q;
    if (mode_d == MODE_RUN) blink_d = 1'b0;
    else if (btn_inc)       blink_d = 1'b0;
    else if (tick_1hz)      blink_d = ~blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign sec_step  = sec_step_q;
  assign min_step  = min_step_q;
  assign hour_step = hour_step_q;
  assign sec_clr   = sec_clr_q;
  assign mode      = mode_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: two instances (default timeout and TIMEOUT_S=3)
// driven one at a time; expected outputs are queued per stimulus cycle and a
// monitor compares them one cycle later.
module tb_clock_set_ctrl;
`ifdef CLOCK_SET_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_tick = 0, a_bm = 0, a_bi = 0, a_sc = 0, a_mc = 0;
  logic b_tick = 0, b_bm = 0, b_bi = 0, b_sc = 0, b_mc = 0;
  logic a_sec, a_min, a_hour, a_clr, a_blink;
  logic b_sec, b_min, b_hour, b_clr, b_blink;
  logic [1:0] a_mode, b_mode;

  always #5 clk = ~clk;

  clock_set_ctrl dut_a (
    .clk(clk), .rst(rst), .tick_1hz(a_tick), .btn_mode(a_bm), .btn_inc(a_bi),
    .sec_carry(a_sc), .min_carry(a_mc), .sec_step(a_sec), .min_step(a_min),
    .hour_step(a_hour), .sec_clr(a_clr), .mode(a_mode), .blink(a_blink)
  );

  clock_set_ctrl #(.TIMEOUT_S(3)) dut_b (
    .clk(clk), .rst(rst), .tick_1hz(b_tick), .btn_mode(b_bm), .btn_inc(b_bi),
    .sec_carry(b_sc), .min_carry(b_mc), .sec_step(b_sec), .min_step(b_min),
    .hour_step(b_hour), .sec_clr(b_clr), .mode(b_mode), .blink(b_blink)
  );

  typedef struct {
    bit       sel;
    bit [6:0] v;   // {sec, min, hour, clr, mode[1:0], blink}
    string    nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  // Blink expectation only applies when the feature is built.
  function automatic bit [6:0] E(input bit s, input bit m, input bit h,
                                 input bit c, input bit [1:0] md, input bit b);
    return {s, m, h, c, md, b & BL};
  endfunction

  task automatic cyc(input string nm, input bit r, input bit t, input bit bm,
                     input bit bi, input bit sc, input bit mc, input bit [6:0] ev);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (sel) begin
      {b_tick, b_bm, b_bi, b_sc, b_mc} = {t, bm, bi, sc, mc};
      {a_tick, a_bm, a_bi, a_sc, a_mc} = '0;
    end else begin
      {a_tick, a_bm, a_bi, a_sc, a_mc} = {t, bm, bi, sc, mc};
      {b_tick, b_bm, b_bi, b_sc, b_mc} = '0;
    end
    e.sel = sel; e.v = ev; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: outputs reflect the inputs sampled at the preceding edge.
  initial begin
    exp_t e;
    bit [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = e.sel ? {b_sec, b_min, b_hour, b_clr, b_mode, b_blink}
                    : {a_sec, a_min, a_hour, a_clr, a_mode, a_blink};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s dut=%0d got {sec,min,hour,clr,mode,blink}=%b expected %b",
                   e.nm, e.sel, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- DUT A, default timeout ----------------
    sel = 1'b0;
    cyc("reset0",      1, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("reset1",      1, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("idle",        0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    // RUN ripple
    cyc("run_tick",    0, 1, 0, 0, 0, 0, E(1,0,0,0,0,0));
    cyc("run_gap",     0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("run_seccy",   0, 0, 0, 0, 1, 0, E(0,1,0,0,0,0));
    cyc("run_gap2",    0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("run_mincy",   0, 0, 0, 0, 0, 1, E(0,0,1,0,0,0));
    cyc("run_tick_cy", 0, 1, 0, 0, 1, 0, E(1,1,0,0,0,0));
    cyc("run_inc_ign", 0, 0, 0, 1, 0, 0, E(0,0,0,0,0,0));
    // SET_HOUR
    cyc("to_hour",     0, 0, 1, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("hr_tick1",    0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("hr_inc1",     0, 0, 0, 1, 0, 0, E(0,0,1,0,1,0));
    cyc("hr_tick2",    0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("hr_inc2",     0, 0, 0, 1, 0, 0, E(0,0,1,0,1,0));
    cyc("hr_carry_ig", 0, 0, 0, 0, 1, 1, E(0,0,0,0,1,0));
    cyc("hr_inc3",     0, 0, 0, 1, 0, 0, E(0,0,1,0,1,0));
    cyc("hr_tick3",    0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("mode_and_inc",0, 0, 1, 1, 0, 0, E(0,0,0,0,2,0));
    // SET_MIN
    cyc("mn_blink1",   0, 1, 0, 0, 0, 0, E(0,0,0,0,2,1));
    cyc("mn_blink0",   0, 1, 0, 0, 0, 0, E(0,0,0,0,2,0));
    cyc("mn_blink1b",  0, 1, 0, 0, 0, 0, E(0,0,0,0,2,1));
    cyc("mn_blink0b",  0, 1, 0, 0, 0, 0, E(0,0,0,0,2,0));
    cyc("mn_inc",      0, 0, 0, 1, 0, 0, E(0,1,0,0,2,0));
    cyc("mn_tick",     0, 1, 0, 0, 0, 0, E(0,0,0,0,2,1));
    cyc("to_sec",      0, 0, 1, 0, 0, 0, E(0,0,0,0,3,1));
    // SET_SEC
    cyc("sc_clr",      0, 0, 0, 1, 0, 0, E(0,0,0,1,3,0));
    cyc("sc_tick",     0, 1, 0, 0, 0, 0, E(0,0,0,0,3,1));
    cyc("sc_carry_ig", 0, 0, 0, 0, 1, 0, E(0,0,0,0,3,1));
    cyc("to_run",      0, 0, 1, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("run_again",   0, 1, 0, 0, 0, 0, E(1,0,0,0,0,0));
    // Reset in SET_MIN with an increment pending
    cyc("rs_hour",     0, 0, 1, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("rs_min",      0, 0, 1, 0, 0, 0, E(0,0,0,0,2,0));
    cyc("rs_reset",    1, 0, 0, 1, 0, 0, E(0,0,0,0,0,0));
    cyc("rs_after",    0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("rs_run_tick", 0, 1, 0, 0, 0, 0, E(1,0,0,0,0,0));

    // ---------------- DUT B, TIMEOUT_S = 3 ----------------
    sel = 1'b1;
    cyc("to_enter",    0, 0, 1, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("to_t1",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("to_t2",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("to_t3_exp",   0, 1, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("to_idle",     0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("kk_enter",    0, 0, 1, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("kk_t1",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("kk_t2",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("kk_inc",      0, 0, 0, 1, 0, 0, E(0,0,1,0,1,0));
    cyc("kk_t3",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("kk_t4",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("kk_t5_exp",   0, 1, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("bw_enter",    0, 0, 1, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("bw_t1",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,1));
    cyc("bw_t2",       0, 1, 0, 0, 0, 0, E(0,0,0,0,1,0));
    cyc("bw_t3_btn",   0, 1, 1, 0, 0, 0, E(0,0,0,0,2,1));
    cyc("bw_t1b",      0, 1, 0, 0, 0, 0, E(0,0,0,0,2,0));
    cyc("bw_t2b",      0, 1, 0, 0, 0, 0, E(0,0,0,0,2,1));
    cyc("bw_t3b_exp",  0, 1, 0, 0, 0, 0, E(0,0,0,0,0,0));
    cyc("end_idle",    0, 0, 0, 0, 0, 0, E(0,0,0,0,0,0));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
